// File: rtl/rs_issue_select_pkg.sv
// Shared types and sizing for the reservation-station issue selector.
package rs_issue_select_pkg;

    localparam int unsigned RS_SZ       = 8;
    localparam int unsigned LANES       = 3;
    localparam int unsigned RS_IDX_BITS = $clog2(RS_SZ);
    localparam int unsigned CNT_W       = $clog2(LANES + 1);
    localparam int unsigned TAG_W       = 6;
    localparam int unsigned B_MASK_W    = 4;
    localparam int unsigned PAYLOAD_W   = 16;

    typedef logic [B_MASK_W-1:0] b_mask_t;

    typedef struct packed {
        b_mask_t              b_mask;
        logic [TAG_W-1:0]     dest_tag;
        logic [TAG_W-1:0]     source1;
        logic                 source1_ready;
        logic [TAG_W-1:0]     source2;
        logic                 source2_ready;
        logic [PAYLOAD_W-1:0] payload;
    } rs_packet_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } cdb_etb_packet_t;

    // Modular add on RS indices; RS_SZ need not be a power of two.
    function automatic logic [RS_IDX_BITS-1:0] rs_idx_add(input logic [RS_IDX_BITS-1:0] base,
                                                          input int unsigned off);
        logic [RS_IDX_BITS:0] sum;
        sum = {1'b0, base} + (RS_IDX_BITS+1)'(off);
        if (sum >= (RS_IDX_BITS+1)'(RS_SZ)) begin
            sum = sum - (RS_IDX_BITS+1)'(RS_SZ);
        end
        return sum[RS_IDX_BITS-1:0];
    endfunction

endpackage

// File: rtl/rs_issue_select_rr_psel.sv
// Rotating-priority multi-grant selector: up to max_picks_i grants starting from rr_ptr_i.
module rs_issue_select_rr_psel
    import rs_issue_select_pkg::*;
(
    input  logic [RS_SZ-1:0]                  req_i,
    input  logic [RS_IDX_BITS-1:0]            rr_ptr_i,
    input  logic [CNT_W-1:0]                  max_picks_i,
    output logic [LANES-1:0][RS_SZ-1:0]       gnt_bus_o,
    output logic [LANES-1:0][RS_IDX_BITS-1:0] pick_idx_o,
    output logic [CNT_W-1:0]                  pick_cnt_o,
    output logic [RS_IDX_BITS-1:0]            last_idx_o
);

    logic [RS_IDX_BITS-1:0] rot_idx [RS_SZ];

    always_comb begin
        for (int unsigned k = 0; k < RS_SZ; k++) begin
            rot_idx[k] = rs_idx_add(rr_ptr_i, k);
        end
    end

    // Walk requests in rotated order; grant number n lands in row n of gnt_bus_o.
    always_comb begin
        gnt_bus_o  = '0;
        pick_idx_o = '0;
        pick_cnt_o = '0;
        last_idx_o = '0;
        for (int unsigned k = 0; k < RS_SZ; k++) begin
            if (req_i[rot_idx[k]] && (pick_cnt_o < max_picks_i)) begin
                gnt_bus_o[pick_cnt_o][rot_idx[k]] = 1'b1;
                pick_idx_o[pick_cnt_o]            = rot_idx[k];
                last_idx_o                        = rot_idx[k];
                pick_cnt_o                        = pick_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rs_issue_select.sv
// Issue-side RS reader: wakeup-bypassed ready check, rotating-priority pick into free lanes,
// per-lane issue registers with valid/ready handshake and branch squash/resolve.
module rs_issue_select
    import rs_issue_select_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  rs_packet_t      [RS_SZ-1:0]       rs_data_i,
    input  logic            [RS_SZ-1:0]       rs_valid_next_i,
    input  cdb_etb_packet_t [LANES-1:0]       etb_tags_i,
    output logic            [RS_SZ-1:0]       rs_data_issuing_o,
    input  logic            [LANES-1:0]       fu_ready_i,
    output rs_packet_t      [LANES-1:0]       issue_pkt_o,
    output logic            [LANES-1:0]       issue_valid_o,
    input  b_mask_t                           b_mm_resolve_i,
    input  logic                              b_mm_mispred_i
);

    logic       [RS_SZ-1:0]                ready;
    logic       [LANES-1:0]                lane_free;
    logic       [CNT_W-1:0]                free_cnt;
    logic       [CNT_W-1:0]                max_picks;
    logic       [LANES-1:0][RS_SZ-1:0]     gnt_bus;
    logic       [LANES-1:0][RS_IDX_BITS-1:0] pick_idx;
    logic       [CNT_W-1:0]                pick_cnt;
    logic       [RS_IDX_BITS-1:0]          last_idx;
    logic       [CNT_W-1:0]                slot;

    rs_packet_t [LANES-1:0]                issue_pkt_q, issue_pkt_d;
    logic       [LANES-1:0]                issue_valid_q, issue_valid_d;
    logic       [RS_IDX_BITS-1:0]          rr_ptr_q, rr_ptr_d;

    // A source is satisfied if already ready or its tag is broadcast this cycle.
    always_comb begin
        for (int unsigned j = 0; j < RS_SZ; j++) begin
            logic s1_ok;
            logic s2_ok;
            s1_ok = rs_data_i[j].source1_ready;
            s2_ok = rs_data_i[j].source2_ready;
            for (int unsigned l = 0; l < LANES; l++) begin
                if (etb_tags_i[l].valid && (etb_tags_i[l].tag == rs_data_i[j].source1)) s1_ok = 1'b1;
                if (etb_tags_i[l].valid && (etb_tags_i[l].tag == rs_data_i[j].source2)) s2_ok = 1'b1;
            end
            ready[j] = rs_valid_next_i[j] & s1_ok & s2_ok;
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_free[i] = ~issue_valid_q[i] | fu_ready_i[i];
            free_cnt     = free_cnt + CNT_W'(lane_free[i]);
        end
        max_picks = reset_i ? '0 : free_cnt;
    end

    rs_issue_select_rr_psel u_rr_psel (
        .req_i       (ready),
        .rr_ptr_i    (rr_ptr_q),
        .max_picks_i (max_picks),
        .gnt_bus_o   (gnt_bus),
        .pick_idx_o  (pick_idx),
        .pick_cnt_o  (pick_cnt),
        .last_idx_o  (last_idx)
    );

    always_comb begin
        rs_data_issuing_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            rs_data_issuing_o = rs_data_issuing_o | gnt_bus[i];
        end
    end

    // The n-th pick goes to the n-th free lane in ascending lane order.
    always_comb begin
        issue_pkt_d   = issue_pkt_q;
        issue_valid_d = issue_valid_q;
        slot          = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            issue_pkt_d[i].b_mask = issue_pkt_q[i].b_mask & ~b_mm_resolve_i;
            if (lane_free[i] && (slot < pick_cnt)) begin
                issue_pkt_d[i]        = rs_data_i[pick_idx[slot]];
                issue_pkt_d[i].b_mask = rs_data_i[pick_idx[slot]].b_mask & ~b_mm_resolve_i;
                issue_valid_d[i]      = 1'b1;
                slot                  = slot + CNT_W'(1);
            end else if (fu_ready_i[i]) begin
                issue_valid_d[i] = 1'b0;
            end else if (b_mm_mispred_i && |(issue_pkt_q[i].b_mask & b_mm_resolve_i)) begin
                issue_valid_d[i] = 1'b0;
            end
        end
        rr_ptr_d = (pick_cnt != '0) ? rs_idx_add(last_idx, 1) : rr_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            issue_pkt_q   <= '0;
            issue_valid_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            issue_pkt_q   <= issue_pkt_d;
            issue_valid_q <= issue_valid_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign issue_pkt_o   = issue_pkt_q;
    assign issue_valid_o = issue_valid_q;

endmodule

// File: tb/tb_rs_issue_select.sv
// Randomized and directed bench for rs_issue_select against a queue-based reference model.
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              rst;
    rs_packet_t      [RS_SZ-1:0]       rs_data;
    logic            [RS_SZ-1:0]       rs_valid_next;
    cdb_etb_packet_t [LANES-1:0]       etb;
    logic            [RS_SZ-1:0]       rs_data_issuing;
    logic            [LANES-1:0]       fu_ready;
    rs_packet_t      [LANES-1:0]       issue_pkt;
    logic            [LANES-1:0]       issue_valid;
    b_mask_t                           resolve;
    logic                              mispred;

    rs_issue_select dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .rs_data_i         (rs_data),
        .rs_valid_next_i   (rs_valid_next),
        .etb_tags_i        (etb),
        .rs_data_issuing_o (rs_data_issuing),
        .fu_ready_i        (fu_ready),
        .issue_pkt_o       (issue_pkt),
        .issue_valid_o     (issue_valid),
        .b_mm_resolve_i    (resolve),
        .b_mm_mispred_i    (mispred)
    );

    int              n_vec = 0;
    int              n_err = 0;
    int unsigned     m_rr;
    logic [LANES-1:0] m_valid;
    rs_packet_t      m_pkt [LANES];
    logic [RS_SZ-1:0] last_iss;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_ok(input logic [TAG_W-1:0] tag, input logic rdy);
        if (rdy) return 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (etb[l].valid && etb[l].tag == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Apply one cycle: predict picks from current inputs, check the combinational vector,
    // clock the edge, advance the model, then check the lane registers.
    task automatic step();
        int               free_l[$];
        int               cand[$];
        int               npick;
        int               src_of [LANES];
        logic [RS_SZ-1:0] exp_iss;
        exp_iss = '0;
        if (!rst) begin
            for (int i = 0; i < LANES; i++)
                if (!m_valid[i] || fu_ready[i]) free_l.push_back(i);
        end
        for (int k = 0; k < RS_SZ; k++) begin
            int j;
            j = (int'(m_rr) + k) % RS_SZ;
            if (rs_valid_next[j] && src_ok(rs_data[j].source1, rs_data[j].source1_ready)
                                 && src_ok(rs_data[j].source2, rs_data[j].source2_ready))
                cand.push_back(j);
        end
        npick = (free_l.size() < cand.size()) ? free_l.size() : cand.size();
        for (int i = 0; i < LANES; i++) src_of[i] = -1;
        for (int p = 0; p < npick; p++) begin
            exp_iss[cand[p]]  = 1'b1;
            src_of[free_l[p]] = cand[p];
        end
        #1;
        last_iss = rs_data_issuing;
        chk("rs_data_issuing", 64'(rs_data_issuing), 64'(exp_iss));
        @(posedge clk);
        if (rst) begin
            m_valid = '0;
            m_rr    = 0;
            for (int i = 0; i < LANES; i++) m_pkt[i] = '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (src_of[i] >= 0) begin
                    m_pkt[i]        = rs_data[src_of[i]];
                    m_pkt[i].b_mask = m_pkt[i].b_mask & ~resolve;
                    m_valid[i]      = 1'b1;
                end else if (fu_ready[i]) begin
                    m_valid[i] = 1'b0;
                end else if (mispred && ((m_pkt[i].b_mask & resolve) != '0)) begin
                    m_valid[i] = 1'b0;
                end else begin
                    m_pkt[i].b_mask = m_pkt[i].b_mask & ~resolve;
                end
            end
            if (npick > 0) m_rr = unsigned'((cand[npick-1] + 1) % RS_SZ);
        end
        #1;
        chk("issue_valid", 64'(issue_valid), 64'(m_valid));
        for (int i = 0; i < LANES; i++)
            if (m_valid[i]) chk($sformatf("issue_pkt[%0d]", i), 64'(issue_pkt[i]), 64'(m_pkt[i]));
    endtask

    task automatic init_inputs();
        for (int j = 0; j < RS_SZ; j++) begin
            rs_data[j]               = '0;
            rs_data[j].source1       = TAG_W'(j + 16);
            rs_data[j].source2       = TAG_W'(j + 32);
            rs_data[j].source1_ready = 1'b1;
            rs_data[j].source2_ready = 1'b1;
            rs_data[j].payload       = PAYLOAD_W'(j);
        end
        rs_valid_next = '0;
        etb           = '0;
        fu_ready      = '0;
        resolve       = '0;
        mispred       = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        m_rr    = 0;
        m_valid = '0;
        for (int i = 0; i < LANES; i++) m_pkt[i] = '0;
        rst = 1'b1;
        init_inputs();
        step();
        rst = 1'b0;
        chk("reset_valid", 64'(issue_valid), 64'(0));

        // Entries 0,2,5,6 ready, all lanes free, pointer at 0.
        rs_valid_next = 8'b0110_0101;
        step();
        chk("t1_issuing", 64'(last_iss), 64'(8'b0010_0101));
        chk("t1_lane0", 64'(issue_pkt[0].payload), 64'(0));
        chk("t1_lane1", 64'(issue_pkt[1].payload), 64'(2));
        chk("t1_lane2", 64'(issue_pkt[2].payload), 64'(5));
        rs_valid_next = 8'b0100_0000; fu_ready = 3'b111;
        step();
        chk("t1_next_lane0", 64'(issue_pkt[0].payload), 64'(6));
        chk("t1_next_valid", 64'(issue_valid), 64'(3'b001));

        // Pointer at 7: wrap picks 7 then 0.
        rs_valid_next = 8'b1000_0001; fu_ready = 3'b111;
        step();
        chk("t5_issuing", 64'(last_iss), 64'(8'b1000_0001));
        chk("t5_lane0", 64'(issue_pkt[0].payload), 64'(7));
        chk("t5_lane1", 64'(issue_pkt[1].payload), 64'(0));
        rs_valid_next = 8'b0000_0011; fu_ready = 3'b000;
        step();
        chk("t5_ptr1_issuing", 64'(last_iss), 64'(8'b0000_0010));
        chk("t5_ptr1_lane2", 64'(issue_pkt[2].payload), 64'(1));

        // Only lane 1 drains; the other lanes hold.
        rs_valid_next = 8'b0000_1010; fu_ready = 3'b010;
        step();
        chk("t2_issuing", 64'(last_iss), 64'(8'b0000_1000));
        chk("t2_valid", 64'(issue_valid), 64'(3'b111));
        chk("t2_lane0", 64'(issue_pkt[0].payload), 64'(7));
        chk("t2_lane1", 64'(issue_pkt[1].payload), 64'(3));
        chk("t2_lane2", 64'(issue_pkt[2].payload), 64'(1));

        // Wakeup bypass on source2.
        rs_valid_next = 8'b0001_0000; fu_ready = 3'b111;
        rs_data[4].source2_ready = 1'b0;
        rs_data[4].source2       = 6'd5;
        rs_data[4].b_mask        = 4'b0100;
        etb[0] = '{valid: 1'b1, tag: 6'd9};
        etb[1] = '{valid: 1'b0, tag: 6'd5};
        step();
        chk("t3_no_bypass", 64'(last_iss), 64'(0));
        etb[1].valid = 1'b1;
        step();
        chk("t3_bypass", 64'(last_iss), 64'(8'b0001_0000));
        chk("t3_lane0", 64'(issue_pkt[0].payload), 64'(4));
        chk("t3_bmask", 64'(issue_pkt[0].b_mask), 64'(4'b0100));

        // Mispredict squashes a stalled lane; a correct resolve clears the mask bit.
        rs_valid_next = '0; etb = '0; fu_ready = '0; resolve = 4'b0100; mispred = 1'b1;
        step();
        chk("t4_squash", 64'(issue_valid), 64'(3'b000));
        resolve = '0; mispred = 1'b0; rs_valid_next = 8'b0001_0000; etb[1] = '{valid: 1'b1, tag: 6'd5};
        step();
        rs_valid_next = '0; etb = '0; resolve = 4'b0100;
        step();
        chk("t4_resolve_valid", 64'(issue_valid[0]), 64'(1));
        chk("t4_resolve_bmask", 64'(issue_pkt[0].b_mask), 64'(0));

        // Reset mid-stream.
        init_inputs();
        rs_valid_next = 8'hFF; fu_ready = 3'b111;
        step();
        rst = 1'b1;
        step();
        chk("t6_issuing", 64'(last_iss), 64'(0));
        chk("t6_valid", 64'(issue_valid), 64'(0));
        chk("t6_pkt", 64'(issue_pkt), 64'(0));
        rst = 1'b0; rs_valid_next = 8'b1000_0001; fu_ready = 3'b000;
        step();
        chk("t6_ptr0_lane0", 64'(issue_pkt[0].payload), 64'(0));
        chk("t6_ptr0_lane1", 64'(issue_pkt[1].payload), 64'(7));

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < RS_SZ; j++) begin
                r = {$urandom, $urandom};
                rs_data[j]         = r[$bits(rs_packet_t)-1:0];
                rs_data[j].source1 = TAG_W'($urandom_range(0, 7));
                rs_data[j].source2 = TAG_W'($urandom_range(0, 7));
            end
            rs_valid_next = RS_SZ'($urandom);
            for (int l = 0; l < LANES; l++) begin
                etb[l].valid = 1'($urandom);
                etb[l].tag   = TAG_W'($urandom_range(0, 7));
            end
            fu_ready = LANES'($urandom);
            resolve  = ($urandom_range(0, 2) == 0) ? b_mask_t'(1 << $urandom_range(0, 3)) : '0;
            mispred  = 1'($urandom);
            rst      = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
